// File: rtl/collision_clearance_ctrl.sv
// Ambulance dispatch/dwell/return sequencer with scene-clear req/ack; freezes cars while busy.
// Optional dispatch watchdog under `CLEARANCE_WATCHDOG_EN (default build: timeout tied 0).
module collision_clearance_ctrl #(
  parameter int DWELL_TICKS    = 3,
  parameter int SPEED          = 8,
  parameter int AMB_LEN        = 100,
  parameter int HOME_R         = 924,
  parameter int HOME_B         = 668,
  parameter int WATCHDOG_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_hz_enable,
  input  logic        is_collision,
  input  logic [1:0]  ambulance_move_dir,
  input  logic [10:0] ambulance_dest_x,
  input  logic [9:0]  ambulance_dest_y,
  input  logic [10:0] ambulance_leftx,
  input  logic [9:0]  ambulance_topy,
  input  logic        clear_ack,
  output logic        cars_frozen,
  output logic        amb_return_active,
  output logic [10:0] amb_ret_leftx,
  output logic [9:0]  amb_ret_topy,
  output logic        clear_req,
  output logic [2:0]  state,
  output logic        timeout
);

  localparam logic [1:0] MOVE_UP    = 2'd0;
  localparam logic [1:0] MOVE_DOWN  = 2'd1;
  localparam logic [1:0] MOVE_LEFT  = 2'd2;
  localparam logic [1:0] MOVE_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DISPATCH   = 3'd1,
    S_ON_SCENE   = 3'd2,
    S_RETURN     = 3'd3,
    S_CLEAR_WAIT = 3'd4
  } state_t;

  typedef logic [$clog2(WATCHDOG_TICKS + 1)-1:0] wd_t;

  state_t      cur_state, next_state;
  logic        prev_coll, start;
  logic [1:0]  dir_q;
  logic [10:0] dest_x_q;
  logic [9:0]  dest_y_q;
  logic [7:0]  dwell_cnt;
  logic        arrived, ret_done, wd_fire;

  assign start = is_collision & ~prev_coll;

  // 12-bit compares so dest+SPEED+AMB_LEN cannot wrap.
  always_comb begin
    arrived = 1'b0;
    case (dir_q)
      MOVE_LEFT:  arrived = {1'b0, ambulance_leftx} <= {1'b0, dest_x_q} + 12'(SPEED);
      MOVE_RIGHT: arrived = {1'b0, ambulance_leftx} + 12'(SPEED + AMB_LEN) >= {1'b0, dest_x_q};
      MOVE_UP:    arrived = {2'b0, ambulance_topy} <= {2'b0, dest_y_q} + 12'(SPEED);
      default:    arrived = {2'b0, ambulance_topy} + 12'(SPEED + AMB_LEN) >= {2'b0, dest_y_q};
    endcase
  end

  always_comb begin
    ret_done = 1'b0;
    case (dir_q)
      MOVE_LEFT:  ret_done = {1'b0, amb_ret_leftx} + 12'(SPEED) >= 12'(HOME_R);
      MOVE_RIGHT: ret_done = amb_ret_leftx <= 11'(SPEED);
      MOVE_UP:    ret_done = {2'b0, amb_ret_topy} + 12'(SPEED) >= 12'(HOME_B);
      default:    ret_done = amb_ret_topy <= 10'(SPEED);
    endcase
  end

`ifdef CLEARANCE_WATCHDOG_EN
  wd_t wd_cnt;
  logic timeout_q;
  assign wd_fire = (cur_state == S_DISPATCH) && !arrived && is_collision &&
                   one_hz_enable && (wd_cnt == wd_t'(WATCHDOG_TICKS - 1));
  assign timeout = timeout_q;

  // Counter sits at zero outside DISPATCH, so each dispatch starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (cur_state != S_DISPATCH) wd_cnt <= '0;
      else if (one_hz_enable)      wd_cnt <= wd_cnt + wd_t'(1);
      if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE:       if (start) next_state = S_DISPATCH;
      S_DISPATCH: begin
        if (arrived)            next_state = S_ON_SCENE;
        else if (!is_collision) next_state = S_RETURN;
        else if (wd_fire)       next_state = S_RETURN;
      end
      S_ON_SCENE:   if (one_hz_enable && dwell_cnt == 8'd1) next_state = S_RETURN;
      S_RETURN:     if (one_hz_enable && ret_done) next_state = S_CLEAR_WAIT;
      S_CLEAR_WAIT: if (clear_ack) next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state     <= S_IDLE;
      prev_coll     <= 1'b0;
      dir_q         <= 2'd0;
      dest_x_q      <= '0;
      dest_y_q      <= '0;
      dwell_cnt     <= '0;
      amb_ret_leftx <= '0;
      amb_ret_topy  <= '0;
    end else begin
      cur_state <= next_state;
      prev_coll <= is_collision;
      if (cur_state == S_IDLE && start) begin
        dir_q    <= ambulance_move_dir;
        dest_x_q <= ambulance_dest_x;
        dest_y_q <= ambulance_dest_y;
      end
      if (cur_state == S_DISPATCH && next_state == S_ON_SCENE)
        dwell_cnt <= 8'(DWELL_TICKS);
      else if (cur_state == S_ON_SCENE && one_hz_enable)
        dwell_cnt <= dwell_cnt - 8'd1;
      // Return trip starts from wherever the mover left the ambulance.
      if (cur_state != S_RETURN && next_state == S_RETURN) begin
        amb_ret_leftx <= ambulance_leftx;
        amb_ret_topy  <= ambulance_topy;
      end else if (cur_state == S_RETURN && one_hz_enable) begin
        case (dir_q)
          MOVE_LEFT:  amb_ret_leftx <= ret_done ? 11'(HOME_R) : amb_ret_leftx + 11'(SPEED);
          MOVE_RIGHT: amb_ret_leftx <= ret_done ? 11'd0 : amb_ret_leftx - 11'(SPEED);
          MOVE_UP:    amb_ret_topy  <= ret_done ? 10'(HOME_B) : amb_ret_topy + 10'(SPEED);
          default:    amb_ret_topy  <= ret_done ? 10'd0 : amb_ret_topy - 10'(SPEED);
        endcase
      end
    end
  end

  assign state             = cur_state;
  assign cars_frozen       = cur_state != S_IDLE;
  assign amb_return_active = cur_state == S_RETURN;
  assign clear_req         = cur_state == S_CLEAR_WAIT;

endmodule

// File: tb/tb_collision_clearance_ctrl.sv
// Directed bench for collision_clearance_ctrl; watchdog expectations follow `CLEARANCE_WATCHDOG_EN.
module tb_collision_clearance_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        one_hz_enable;
  logic        is_collision;
  logic [1:0]  ambulance_move_dir;
  logic [10:0] ambulance_dest_x;
  logic [9:0]  ambulance_dest_y;
  logic [10:0] ambulance_leftx;
  logic [9:0]  ambulance_topy;
  logic        clear_ack;
  logic        cars_frozen;
  logic        amb_return_active;
  logic [10:0] amb_ret_leftx;
  logic [9:0]  amb_ret_topy;
  logic        clear_req;
  logic [2:0]  state;
  logic        timeout;

  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  int checks = 0;
  int failures = 0;

  collision_clearance_ctrl dut (
    .clk(clk), .reset(reset), .one_hz_enable(one_hz_enable), .is_collision(is_collision),
    .ambulance_move_dir(ambulance_move_dir), .ambulance_dest_x(ambulance_dest_x),
    .ambulance_dest_y(ambulance_dest_y), .ambulance_leftx(ambulance_leftx),
    .ambulance_topy(ambulance_topy), .clear_ack(clear_ack), .cars_frozen(cars_frozen),
    .amb_return_active(amb_return_active), .amb_ret_leftx(amb_ret_leftx),
    .amb_ret_topy(amb_ret_topy), .clear_req(clear_req), .state(state), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      one_hz_enable = 1'b1;
      step();
      one_hz_enable = 1'b0;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; one_hz_enable = 1'b0; is_collision = 1'b0; clear_ack = 1'b0;
    ambulance_move_dir = LEFT; ambulance_dest_x = 11'd500; ambulance_dest_y = 10'd0;
    ambulance_leftx = 11'd924; ambulance_topy = 10'd400;
    step(); step();
    check("rst_state", state, 0);
    check("rst_frozen", cars_frozen, 0);
    check("rst_ret_active", amb_return_active, 0);
    check("rst_clear_req", clear_req, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ret_xy", {amb_ret_leftx, amb_ret_topy}, 0);
    reset = 1'b0;
    step();

    // 1: MOVE_LEFT to x=500, home right at 924
    is_collision = 1'b1;
    step();
    check("t1_dispatch", state, 1);
    check("t1_frozen", cars_frozen, 1);
    step();
    check("t1_no_arrive_924", state, 1);
    ambulance_leftx = 11'd508;
    step();
    check("t1_on_scene", state, 2);
    tick_n(2);
    check("t1_dwell_2", state, 2);
    tick_n(1);
    check("t1_return", state, 3);
    check("t1_ret_active", amb_return_active, 1);
    check("t1_ret_x_load", amb_ret_leftx, 508);
    check("t1_ret_y_load", amb_ret_topy, 400);
    tick_n(51);
    check("t1_ret_51", {state, 5'd0, amb_ret_leftx}, {3'd3, 5'd0, 11'd916});
    tick_n(1);
    check("t1_home_x", amb_ret_leftx, 924);
    check("t1_held_y", amb_ret_topy, 400);
    check("t1_clear_wait", state, 4);
    check("t1_clear_req", clear_req, 1);
    step();
    check("t1_wait_ack", state, 4);
    clear_ack = 1'b1;
    step();
    clear_ack = 1'b0;
    check("t1_idle", state, 0);
    check("t1_unfrozen", cars_frozen, 0);
    step(); step();
    check("t1_no_redispatch", state, 0);
    is_collision = 1'b0;
    step();

    // 2: MOVE_DOWN to y=300, home at topy 0
    ambulance_move_dir = DOWN; ambulance_dest_y = 10'd300;
    ambulance_topy = 10'd100; ambulance_leftx = 11'd300;
    is_collision = 1'b1;
    step();
    check("t2_dispatch", state, 1);
    ambulance_topy = 10'd191;
    step();
    check("t2_191_no_arrive", state, 1);
    ambulance_topy = 10'd192;
    step();
    check("t2_192_on_scene", state, 2);
    tick_n(3);
    check("t2_return", state, 3);
    check("t2_ret_y_load", amb_ret_topy, 192);
    check("t2_ret_x_load", amb_ret_leftx, 300);
    tick_n(23);
    check("t2_ret_23", {state, 6'd0, amb_ret_topy}, {3'd3, 6'd0, 10'd8});
    tick_n(1);
    check("t2_home_y", amb_ret_topy, 0);
    check("t2_clear_wait", state, 4);
    clear_ack = 1'b1; is_collision = 1'b0;
    step();
    clear_ack = 1'b0;
    check("t2_idle", state, 0);

    // 3a: abort in DISPATCH skips the dwell; MOVE_UP return takes ceil(68/8)=9 ticks
    ambulance_move_dir = UP; ambulance_dest_y = 10'd200; ambulance_topy = 10'd600;
    is_collision = 1'b1;
    step();
    check("t3_dispatch", state, 1);
    is_collision = 1'b0;
    step();
    check("t3_abort_return", state, 3);
    check("t3_ret_y_load", amb_ret_topy, 600);
    tick_n(8);
    check("t3_ret_8", {state, 6'd0, amb_ret_topy}, {3'd3, 6'd0, 10'd664});
    tick_n(1);
    check("t3_home_y", amb_ret_topy, 668);
    check("t3_clear_wait", state, 4);
    clear_ack = 1'b1;
    step();
    clear_ack = 1'b0;
    check("t3_idle", state, 0);

    // 3b: arrival and drop in the same cycle -> arrival wins
    ambulance_move_dir = RIGHT; ambulance_dest_x = 11'd600; ambulance_leftx = 11'd100;
    is_collision = 1'b1;
    step();
    check("t3b_dispatch", state, 1);
    ambulance_leftx = 11'd492; is_collision = 1'b0;
    step();
    check("t3b_arrive_wins", state, 2);

    // 4: clear_ack held through ON_SCENE and RETURN is ignored
    clear_ack = 1'b1;
    tick_n(2);
    check("t4_ack_on_scene", state, 2);
    tick_n(1);
    check("t4_ack_return", state, 3);
    check("t4_ret_x_load", amb_ret_leftx, 492);
    tick_n(61);
    check("t4_ret_61", {state, 5'd0, amb_ret_leftx}, {3'd3, 5'd0, 11'd4});
    clear_ack = 1'b0;
    tick_n(1);
    check("t4_home_x", amb_ret_leftx, 0);
    check("t4_clear_wait", state, 4);
    is_collision = 1'b1;
    step();
    check("t4_start_ignored", state, 4);
    clear_ack = 1'b1;
    step();
    clear_ack = 1'b0;
    check("t4_idle", state, 0);
    step(); step();
    check("t4_coll_high_no_redispatch", state, 0);
    is_collision = 1'b0;
    step();
    ambulance_move_dir = LEFT; ambulance_dest_x = 11'd500; ambulance_leftx = 11'd508;
    is_collision = 1'b1;
    step();
    check("t4_redispatch", state, 1);

    // 5: async reset mid ON_SCENE with collision held high
    step();
    check("t5_on_scene", state, 2);
    tick_n(1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_state", state, 0);
    check("t5_async_outs", {cars_frozen, amb_return_active, clear_req, timeout}, 0);
    check("t5_async_ret_y", amb_ret_topy, 0);
    step(); step();
    ambulance_leftx = 11'd924;
    reset = 1'b0;
    step();
    check("t5_dispatch_after_rst", state, 1);

    // 6: watchdog, no arrival
    tick_n(9);
    check("t6_tick9", state, 1);
`ifdef CLEARANCE_WATCHDOG_EN
    tick_n(1);
    check("t6_wd_return", state, 3);
    check("t6_timeout", timeout, 1);
    tick_n(3);
    check("t6_timeout_sticky", timeout, 1);
`else
    tick_n(1);
    check("t6_no_wd_state", state, 1);
    check("t6_no_timeout", timeout, 0);
    tick_n(3);
    check("t6_still_dispatch", state, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
